// File: rtl/sbox_arbiter.sv
// rtl/sbox_arbiter.sv - shares one pipelined S-box between the round datapath and key expansion
// Optional macro SBOX_ARBITER_KEY_PRIO_EN: key expansion always wins a simultaneous request.
module sbox_arbiter #(
  parameter int SBOX_LAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d_req,
  input  logic [127:0] d_in,
  output logic         d_done,
  output logic [127:0] d_out,
  input  logic         k_req,
  input  logic [31:0]  k_in,
  output logic         k_done,
  output logic [31:0]  k_out,
  output logic [7:0]   sbox_x,
  input  logic [7:0]   sbox_y,
  output logic         sbox_vld,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                is_k;
  logic [127:0]        word, res, res_nxt;
  logic [3:0]          cnt, last_idx;
  logic [SBOX_LAT-1:0] pv;
  logic [3:0]          pidx [SBOX_LAT];
  logic                d_elig, k_elig, grant, grant_k, cap, last_cap;

  // A requester whose done is high this cycle is not eligible, so a held req cannot double-grant
  assign d_elig = d_req & ~d_done;
  assign k_elig = k_req & ~k_done;
  assign grant  = (state == IDLE) & (d_elig | k_elig);

`ifdef SBOX_ARBITER_KEY_PRIO_EN
  assign grant_k = k_elig;
`else
  logic prefer_k;

  assign grant_k = k_elig & (~d_elig | prefer_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_k <= 1'b0;
    end else if (grant) begin
      prefer_k <= ~grant_k;
    end
  end
`endif

  assign last_idx = is_k ? 4'd3 : 4'd15;
  assign cap      = pv[SBOX_LAT-1];
  assign last_cap = cap & (pidx[SBOX_LAT-1] == last_idx);
  assign sbox_vld = (state == ISSUE);
  assign sbox_x   = sbox_vld ? word[{cnt, 3'b000} +: 8] : 8'h00;
  assign busy     = (state != IDLE);

  always_comb begin
    res_nxt = res;
    if (cap) begin
      res_nxt[{pidx[SBOX_LAT-1], 3'b000} +: 8] = sbox_y;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (cnt == last_idx) state_nxt = DRAIN;
      DRAIN:   if (last_cap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_k   <= 1'b0;
      word   <= '0;
      res    <= '0;
      cnt    <= '0;
      d_done <= 1'b0;
      k_done <= 1'b0;
      d_out  <= '0;
      k_out  <= '0;
    end else begin
      d_done <= 1'b0;
      k_done <= 1'b0;
      if (grant) begin
        is_k <= grant_k;
        word <= grant_k ? {96'd0, k_in} : d_in;
        cnt  <= '0;
      end else if (state == ISSUE) begin
        cnt <= cnt + 4'd1;
      end
      res <= res_nxt;
      if (state == DRAIN && last_cap) begin
        if (is_k) begin
          k_done <= 1'b1;
          k_out  <= res_nxt[31:0];
        end else begin
          d_done <= 1'b1;
          d_out  <= res_nxt;
        end
      end
    end
  end

  // Tags each issued byte with its index so the S-box result lands in the right lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < SBOX_LAT; i++) pidx[i] <= '0;
    end else begin
      pv[0]   <= sbox_vld;
      pidx[0] <= cnt;
      for (int i = 1; i < SBOX_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb/tb_sbox_arbiter.sv - self-checking bench for sbox_arbiter with a pipelined AES S-box model
module tb_sbox_arbiter;

  localparam int LAT = 5;
  localparam logic [127:0] VEC_D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES_D = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  VEC_K = 32'h09cf4f3c;
  localparam logic [31:0]  RES_K = 32'h018a84eb;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct packed {
    logic         is_k;
    logic [127:0] data;
    logic [7:0]   lat;
    logic [7:0]   nbytes;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d_req = 1'b0, k_req = 1'b0;
  logic [127:0] d_in = '0;
  logic [31:0]  k_in = '0;
  logic         d_done, k_done, sbox_vld, busy;
  logic [127:0] d_out;
  logic [31:0]  k_out;
  logic [7:0]   sbox_x, sbox_y;
  logic [7:0]   spipe [LAT];

  int   n_cmp = 0, n_fail = 0, cyc = 0, obs_rd = 0, grant_cyc = 0, nbytes = 0;
  rec_t obs_q[$], exp_q[$];
  logic busy_q = 1'b0, both_hi = 1'b0;

  sbox_arbiter #(.SBOX_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_in(d_in), .d_done(d_done), .d_out(d_out),
    .k_req(k_req), .k_in(k_in), .k_done(k_done), .k_out(k_out),
    .sbox_x(sbox_x), .sbox_y(sbox_y), .sbox_vld(sbox_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  // External S-box: never reset, so stale bytes keep flowing out after a DUT reset
  always @(posedge clk) begin
    spipe[0] <= SBOX[sbox_x];
    for (int i = 1; i < LAT; i++) spipe[i] <= spipe[i-1];
    cyc <= cyc + 1;
  end
  assign sbox_y = spipe[LAT-1];

  function automatic rec_t model(input logic is_k, input logic [127:0] in);
    rec_t r;
    int   n = is_k ? 4 : 16;
    r.is_k = is_k;
    r.data = '0;
    for (int i = 0; i < n; i++) r.data[i*8 +: 8] = SBOX[in[i*8 +: 8]];
    r.lat    = 8'(n + LAT + 1);
    r.nbytes = 8'(n);
    return r;
  endfunction

  function automatic rec_t mk_rec(input logic is_k, input logic [127:0] data, input int lat, input int nb);
    rec_t r;
    r.is_k   = is_k;
    r.data   = data;
    r.lat    = 8'(lat);
    r.nbytes = 8'(nb);
    return r;
  endfunction

  always @(negedge clk) begin
    busy_q <= busy;
    if (busy && !busy_q) begin
      grant_cyc <= cyc - 1;
      nbytes    <= sbox_vld ? 1 : 0;
    end else if (sbox_vld) begin
      nbytes <= nbytes + 1;
    end
    if (d_done && k_done) both_hi <= 1'b1;
    if (d_done) obs_q.push_back(mk_rec(1'b0, d_out, cyc - grant_cyc, nbytes));
    if (k_done) obs_q.push_back(mk_rec(1'b1, {96'd0, k_out}, cyc - grant_cyc, nbytes));
  end

  task automatic run_until(input int ndone, input int budget);
    int start = obs_q.size();
    for (int n = 0; n < budget && obs_q.size() - start < ndone; n++) begin
      @(negedge clk);
      #1;
    end
    d_req = 1'b0;
    k_req = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    d_req = 1'b0;
    k_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({d_done, k_done, sbox_vld, busy, sbox_x, d_out, k_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {d_done, k_done, sbox_vld, busy, sbox_x, d_out, k_out});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single_d;
    logic seen = 1'b0;
    do_reset();
    d_in = VEC_D;
    exp_q.push_back(model(1'b0, VEC_D));
    d_req = 1'b1;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (d_done) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_d_no_regrant: busy got %b required 0", busy); end
    n_cmp++;
    if (obs_rd >= obs_q.size()) begin
      n_fail++; $display("FAIL single_d_job: no done seen, required %h", exp_q[0]);
    end else if (obs_q[obs_rd] !== exp_q[0]) begin
      n_fail++; $display("FAIL single_d_job: got %h required %h", obs_q[obs_rd], exp_q[0]);
    end
    obs_rd++;
    void'(exp_q.pop_front());
    n_cmp++;
    if (d_out !== RES_D) begin n_fail++; $display("FAIL single_d_out: got %h required %h", d_out, RES_D); end
  endtask

  task automatic test_both_request;
    do_reset();
    d_in = VEC_D;
    k_in = VEC_K;
`ifdef SBOX_ARBITER_KEY_PRIO_EN
    exp_q.push_back(model(1'b1, {96'd0, VEC_K}));
    exp_q.push_back(model(1'b0, VEC_D));
`else
    exp_q.push_back(model(1'b0, VEC_D));
    exp_q.push_back(model(1'b1, {96'd0, VEC_K}));
`endif
    d_req = 1'b1;
    k_req = 1'b1;
    run_until(2, 80);
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin
        n_fail++; $display("FAIL both_job%0d: no done seen, required %h", j, exp_q[0]);
      end else if (obs_q[obs_rd] !== exp_q[0]) begin
        n_fail++; $display("FAIL both_job%0d: got %h required %h", j, obs_q[obs_rd], exp_q[0]);
      end
      obs_rd++;
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (k_out !== RES_K) begin n_fail++; $display("FAIL both_k_out: got %h required %h", k_out, RES_K); end
  endtask

  task automatic test_back_to_back;
    logic first_k;
`ifdef SBOX_ARBITER_KEY_PRIO_EN
    first_k = 1'b1;
`else
    first_k = 1'b0;
`endif
    do_reset();
    d_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    k_in = $urandom();
    for (int j = 0; j < 4; j++) begin
      if (first_k ^ j[0]) exp_q.push_back(model(1'b1, {96'd0, k_in}));
      else exp_q.push_back(model(1'b0, d_in));
    end
    d_req = 1'b1;
    k_req = 1'b1;
    run_until(4, 200);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin
        n_fail++; $display("FAIL b2b_job%0d: no done seen, required %h", j, exp_q[0]);
      end else if (obs_q[obs_rd] !== exp_q[0]) begin
        n_fail++; $display("FAIL b2b_job%0d: got %h required %h", j, obs_q[obs_rd], exp_q[0]);
      end
      obs_rd++;
      void'(exp_q.pop_front());
    end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== obs_rd || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_extra_job: dones got %0d required %0d, busy %b", obs_q.size(), obs_rd, busy);
    end
  endtask

  task automatic test_reset_mid_job;
    int nobs;
    d_in = VEC_D;
    d_req = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_done, k_done, sbox_vld, busy, sbox_x, d_out, k_out} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h required 0", {d_done, k_done, sbox_vld, busy, sbox_x, d_out, k_out});
    end
    d_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_rd = obs_q.size();
    nobs = obs_q.size();
    exp_q.delete();
    k_in = VEC_K;
    exp_q.push_back(model(1'b1, {96'd0, VEC_K}));
    k_req = 1'b1;
    run_until(1, 60);
    n_cmp++;
    if (obs_rd >= obs_q.size()) begin
      n_fail++; $display("FAIL midreset_k_job: no done seen, required %h", exp_q[0]);
    end else if (obs_q[obs_rd] !== exp_q[0]) begin
      n_fail++; $display("FAIL midreset_k_job: got %h required %h", obs_q[obs_rd], exp_q[0]);
    end
    obs_rd++;
    void'(exp_q.pop_front());
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== nobs + 1) begin
      n_fail++; $display("FAIL midreset_done_count: got %0d required %0d", obs_q.size(), nobs + 1);
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_drop_req;
    exp_q.delete();
    d_in = VEC_D;
    exp_q.push_back(model(1'b0, VEC_D));
    d_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    d_req = 1'b0;
    run_until(1, 60);
    n_cmp++;
    if (obs_rd >= obs_q.size()) begin
      n_fail++; $display("FAIL drop_d_job: no done seen, required %h", exp_q[0]);
    end else if (obs_q[obs_rd] !== exp_q[0]) begin
      n_fail++; $display("FAIL drop_d_job: got %h required %h", obs_q[obs_rd], exp_q[0]);
    end
    obs_rd++;
    void'(exp_q.pop_front());
    n_cmp++;
    if (k_out !== RES_K) begin n_fail++; $display("FAIL drop_k_out_kept: got %h required %h", k_out, RES_K); end
    n_cmp++;
    if (both_hi !== 1'b0) begin n_fail++; $display("FAIL dones_exclusive: got %b required 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_single_d();
    test_both_request();
    test_back_to_back();
    test_reset_mid_job();
    test_drop_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
